multi_port_cam_regfile: RTL and testbench
=========================================

MULTI_PORT_CAM_REGFILE -- requirements
Module: multi_port_cam_regfile

Interface
REQ-001 SHALL have parameter SINGLE_ENTRY_SIZE_IN_BITS, default 8: entry width.
REQ-002 SHALL have parameter NUMBER_ENTRY, default 4: entry count, minimum 2.
REQ-003 SHALL have parameter NUMBER_READ_PORT, default 2: read ports, minimum 1.
REQ-004 SHALL have parameter NUMBER_WRITE_PORT, default 2: write ports, minimum 1.
REQ-005 SHALL have port clk_in, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_in, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port read_en_in, input, NUMBER_READ_PORT: per-port read enable.
REQ-008 SHALL have port read_entry_addr_decoded_flatted_in, input, NUMBER_READ_PORT*NUMBER_ENTRY: one-hot address per read port.
REQ-009 SHALL have port read_entry_flatted_out, output, NUMBER_READ_PORT*SINGLE_ENTRY_SIZE_IN_BITS: registered read data.
REQ-010 SHALL have port read_valid_out, output, NUMBER_READ_PORT: read data valid.
REQ-011 SHALL have port write_en_in, input, NUMBER_WRITE_PORT: per-port write enable.
REQ-012 SHALL have port write_entry_addr_decoded_flatted_in, input, NUMBER_WRITE_PORT*NUMBER_ENTRY: one-hot address per write port.
REQ-013 SHALL have port write_entry_flatted_in, input, NUMBER_WRITE_PORT*SINGLE_ENTRY_SIZE_IN_BITS: write data.
REQ-014 SHALL have port invalidate_en_in, input, 1, with invalidate_entry_decoded_in, input, NUMBER_ENTRY: bitmask of entries to clear valid.
REQ-015 SHALL have port cam_en_in, input, 1, with cam_entry_in, input, SINGLE_ENTRY_SIZE_IN_BITS: search key.
REQ-016 SHALL have port cam_result_decoded_out, output, NUMBER_ENTRY, and cam_hit_out, output, 1: registered match vector and any-hit flag.
REQ-017 SHALL have port entry_valid_flatted_out, output, NUMBER_ENTRY: per-entry valid bits.
REQ-018 SHALL have ports free_entry_decoded_out, output, NUMBER_ENTRY (lowest-index invalid entry, one-hot), full_out, output, 1, and empty_out, output, 1.

Function
REQ-019 Write: on the edge, each write port with write_en_in high SHALL store its data to every addressed entry and set that entry's valid bit.
REQ-020 Write conflict: when several write ports address one entry in the same cycle, the highest-index port SHALL win.
REQ-021 Read: read_entry for port p SHALL update one cycle after read_en_in[p] with the OR of addressed entries' data (zero address gives zero); read_valid_out[p] SHALL be high that cycle only if the addressed entry is valid, else low with data zero.
REQ-022 Read with read_en_in[p] low: read_entry and read_valid_out for port p SHALL hold their previous values.
REQ-023 CAM: one cycle after cam_en_in, cam_result_decoded_out[i] SHALL be 1 iff entry i is valid and equals cam_entry_in; cam_hit_out SHALL be the OR of the vector; with cam_en_in low both SHALL hold.
REQ-024 Read and CAM SHALL observe array state before same-edge writes unless REQ-033 applies.
REQ-025 Invalidate: on the edge, addressed valid bits SHALL clear; entry data SHALL be retained.
REQ-026 Write and invalidate to the same entry in one cycle: the write SHALL win and the entry SHALL be valid.
REQ-027 free_entry_decoded_out, full_out and empty_out SHALL be combinational from the valid bits; when full, free_entry_decoded_out SHALL be zero.
REQ-028 Non-one-hot addresses SHALL act on every set bit; no error is flagged.

Reset
REQ-029 reset_in low SHALL immediately clear all valid bits, entry data, read_entry_flatted_out, read_valid_out, cam_result_decoded_out and cam_hit_out.
REQ-030 During and after reset, empty_out SHALL be 1, full_out 0 and free_entry_decoded_out 1 (entry 0).
REQ-031 Reset asserted mid-operation SHALL drop pending writes of that cycle; the first edge after release SHALL be a normal operating edge.

Configuration
REQ-032 Macro MULTI_PORT_CAM_REGFILE_BYPASS_EN SHALL select write-to-read/CAM forwarding.
REQ-033 When defined, reads and CAM searches SHALL see same-cycle writes (REQ-020 priority applies; read_valid_out high); when undefined, REQ-024 holds.

Verification
REQ-034 Reset, then write 8'hA5 to entry 2 via port 0; next cycle read port 1 at 4'b0100 -> read_entry 8'hA5 with read_valid 1 one cycle later.
REQ-035 Ports 0 and 1 write 8'h11 and 8'h22 to entry 1 in the same cycle; read entry 1 -> 8'h22.
REQ-036 Fill entries 0-3 -> full_out 1 and free_entry 0; invalidate 4'b0010 -> full_out 0, free_entry 4'b0010, and a CAM on the old entry-1 data -> no hit.
REQ-037 Write 8'h3C to entries 0 and 3; CAM 8'h3C -> result 4'b1001 with hit 1 one cycle later; CAM 8'h00 after reset -> 0, no hit.
REQ-038 Same-cycle write of 8'h77 to entry 0 and read of entry 0 -> 8'h77 with the macro defined; 8'h00 and valid 0 without it.
REQ-039 Pulse reset_in low between clock edges after writes -> all outputs cleared immediately and empty_out 1.

Source files
------------

// File: rtl/multi_port_cam_regfile.sv
// Multi-port register file with per-entry valid bits and a CAM search port.
// Writes merge by port index (highest index wins), invalidates clear valid
// bits only, reads and CAM results are registered one cycle after enable.
// Optional build macro: MULTI_PORT_CAM_REGFILE_BYPASS_EN forwards same-cycle
// writes into the read and CAM paths.
module multi_port_cam_regfile #(
    parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 8,
    parameter int unsigned NUMBER_ENTRY              = 4,
    parameter int unsigned NUMBER_READ_PORT          = 2,
    parameter int unsigned NUMBER_WRITE_PORT         = 2
) (
    input  logic                                                   clk_in,
    input  logic                                                   reset_in,
    input  logic [NUMBER_READ_PORT-1:0]                            read_en_in,
    input  logic [NUMBER_READ_PORT*NUMBER_ENTRY-1:0]               read_entry_addr_decoded_flatted_in,
    output logic [NUMBER_READ_PORT*SINGLE_ENTRY_SIZE_IN_BITS-1:0]  read_entry_flatted_out,
    output logic [NUMBER_READ_PORT-1:0]                            read_valid_out,
    input  logic [NUMBER_WRITE_PORT-1:0]                           write_en_in,
    input  logic [NUMBER_WRITE_PORT*NUMBER_ENTRY-1:0]              write_entry_addr_decoded_flatted_in,
    input  logic [NUMBER_WRITE_PORT*SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_flatted_in,
    input  logic                                                   invalidate_en_in,
    input  logic [NUMBER_ENTRY-1:0]                                invalidate_entry_decoded_in,
    input  logic                                                   cam_en_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]                   cam_entry_in,
    output logic [NUMBER_ENTRY-1:0]                                cam_result_decoded_out,
    output logic                                                   cam_hit_out,
    output logic [NUMBER_ENTRY-1:0]                                entry_valid_flatted_out,
    output logic [NUMBER_ENTRY-1:0]                                free_entry_decoded_out,
    output logic                                                   full_out,
    output logic                                                   empty_out
);

    localparam int unsigned W  = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int unsigned N  = NUMBER_ENTRY;
    localparam int unsigned RP = NUMBER_READ_PORT;
    localparam int unsigned WP = NUMBER_WRITE_PORT;

    logic [W-1:0]    data_q [N];
    logic [W-1:0]    data_d [N];
    logic [N-1:0]    valid_q, valid_d;
    logic [RP*W-1:0] read_data_q, read_data_d;
    logic [RP-1:0]   read_valid_q, read_valid_d;
    logic [N-1:0]    cam_result_q, cam_result_d;
    logic            cam_hit_q, cam_hit_d;

    logic [N-1:0]    wr_mask_c;
    logic [W-1:0]    wr_data_c [N];
    logic [W-1:0]    view_data_c [N];
    logic [N-1:0]    view_valid_c;

    // Merge all write ports per entry; later (higher-index) ports override earlier ones
    always_comb begin
        wr_mask_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            wr_data_c[i] = '0;
        end
        for (int p = 0; p < int'(WP); p++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (write_en_in[p] && write_entry_addr_decoded_flatted_in[p*N + i]) begin
                    wr_mask_c[i] = 1'b1;
                    wr_data_c[i] = write_entry_flatted_in[p*W +: W];
                end
            end
        end
    end

    // Next array state, and the array view seen by the read and CAM paths
    always_comb begin
        valid_d = (valid_q & ~(invalidate_en_in ? invalidate_entry_decoded_in : {N{1'b0}}))
                | wr_mask_c;
        for (int i = 0; i < int'(N); i++) begin
            data_d[i] = wr_mask_c[i] ? wr_data_c[i] : data_q[i];
`ifdef MULTI_PORT_CAM_REGFILE_BYPASS_EN
            view_data_c[i] = data_d[i];
`else
            view_data_c[i] = data_q[i];
`endif
        end
`ifdef MULTI_PORT_CAM_REGFILE_BYPASS_EN
        view_valid_c = valid_q | wr_mask_c;
`else
        view_valid_c = valid_q;
`endif
    end

    // Read ports and CAM search; disabled ports hold their last result
    always_comb begin
        logic [W-1:0] acc_data;
        logic         acc_valid;
        acc_data     = '0;
        acc_valid    = 1'b0;
        read_data_d  = read_data_q;
        read_valid_d = read_valid_q;
        cam_result_d = cam_result_q;
        cam_hit_d    = cam_hit_q;
        for (int p = 0; p < int'(RP); p++) begin
            if (read_en_in[p]) begin
                acc_data  = '0;
                acc_valid = 1'b0;
                for (int i = 0; i < int'(N); i++) begin
                    if (read_entry_addr_decoded_flatted_in[p*N + i]) begin
                        acc_data  = acc_data | view_data_c[i];
                        acc_valid = acc_valid | view_valid_c[i];
                    end
                end
                read_data_d[p*W +: W] = acc_valid ? acc_data : {W{1'b0}};
                read_valid_d[p]       = acc_valid;
            end
        end
        if (cam_en_in) begin
            for (int i = 0; i < int'(N); i++) begin
                cam_result_d[i] = view_valid_c[i] && (view_data_c[i] == cam_entry_in);
            end
            cam_hit_d = |cam_result_d;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < int'(N); i++) begin
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= '0;
            cam_result_q <= '0;
            cam_hit_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q      <= valid_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            cam_result_q <= cam_result_d;
            cam_hit_q    <= cam_hit_d;
        end
    end

    assign read_entry_flatted_out  = read_data_q;
    assign read_valid_out          = read_valid_q;
    assign cam_result_decoded_out  = cam_result_q;
    assign cam_hit_out             = cam_hit_q;
    assign entry_valid_flatted_out = valid_q;
    // Lowest clear valid bit; the increment wraps to zero when every entry is valid
    assign free_entry_decoded_out  = ~valid_q & (valid_q + N'(1));
    assign full_out                = &valid_q;
    assign empty_out               = ~|valid_q;

endmodule

// File: tb/tb_multi_port_cam_regfile.sv
// Self-checking bench for multi_port_cam_regfile: directed scenarios with
// literal expectations, then randomized traffic against an entry-level model.
module tb_multi_port_cam_regfile;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int RP = 2;
    localparam int WP = 2;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic [RP-1:0]   read_en_in;
    logic [RP*N-1:0] read_entry_addr_decoded_flatted_in;
    logic [RP*W-1:0] read_entry_flatted_out;
    logic [RP-1:0]   read_valid_out;
    logic [WP-1:0]   write_en_in;
    logic [WP*N-1:0] write_entry_addr_decoded_flatted_in;
    logic [WP*W-1:0] write_entry_flatted_in;
    logic            invalidate_en_in;
    logic [N-1:0]    invalidate_entry_decoded_in;
    logic            cam_en_in;
    logic [W-1:0]    cam_entry_in;
    logic [N-1:0]    cam_result_decoded_out;
    logic            cam_hit_out;
    logic [N-1:0]    entry_valid_flatted_out;
    logic [N-1:0]    free_entry_decoded_out;
    logic            full_out;
    logic            empty_out;

    multi_port_cam_regfile #(
        .SINGLE_ENTRY_SIZE_IN_BITS(W),
        .NUMBER_ENTRY(N),
        .NUMBER_READ_PORT(RP),
        .NUMBER_WRITE_PORT(WP)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .read_en_in(read_en_in),
        .read_entry_addr_decoded_flatted_in(read_entry_addr_decoded_flatted_in),
        .read_entry_flatted_out(read_entry_flatted_out),
        .read_valid_out(read_valid_out),
        .write_en_in(write_en_in),
        .write_entry_addr_decoded_flatted_in(write_entry_addr_decoded_flatted_in),
        .write_entry_flatted_in(write_entry_flatted_in),
        .invalidate_en_in(invalidate_en_in),
        .invalidate_entry_decoded_in(invalidate_entry_decoded_in),
        .cam_en_in(cam_en_in),
        .cam_entry_in(cam_entry_in),
        .cam_result_decoded_out(cam_result_decoded_out),
        .cam_hit_out(cam_hit_out),
        .entry_valid_flatted_out(entry_valid_flatted_out),
        .free_entry_decoded_out(free_entry_decoded_out),
        .full_out(full_out),
        .empty_out(empty_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: entry contents and the expected registered outputs
    logic [W-1:0] m_data [N];
    logic [N-1:0] m_valid;
    logic [W-1:0] m_rd [RP];
    logic [RP-1:0] m_rv;
    logic [N-1:0] m_cam;
    logic         m_hit;

    int  n_checks = 0;
    int  n_fail   = 0;
    logic chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] t;
        t = '0;
        t[k] = 1'b1;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_data[i] = '0;
        for (int p = 0; p < RP; p++) m_rd[p] = '0;
        m_valid = '0;
        m_rv    = '0;
        m_cam   = '0;
        m_hit   = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        logic [W-1:0] nd [N];
        logic [N-1:0] wm;
        logic [W-1:0] sd [N];
        logic [N-1:0] sv;
        logic [W-1:0] acc;
        logic         accv;
        wm = '0;
        for (int i = 0; i < N; i++) nd[i] = m_data[i];
        for (int p = 0; p < WP; p++)
            for (int i = 0; i < N; i++)
                if (write_en_in[p] && write_entry_addr_decoded_flatted_in[p*N+i]) begin
                    nd[i] = write_entry_flatted_in[p*W +: W];
                    wm[i] = 1'b1;
                end
        for (int i = 0; i < N; i++) begin
`ifdef MULTI_PORT_CAM_REGFILE_BYPASS_EN
            sd[i] = nd[i];
            sv[i] = m_valid[i] | wm[i];
`else
            sd[i] = m_data[i];
            sv[i] = m_valid[i];
`endif
        end
        for (int p = 0; p < RP; p++)
            if (read_en_in[p]) begin
                acc = '0;
                accv = 1'b0;
                for (int i = 0; i < N; i++)
                    if (read_entry_addr_decoded_flatted_in[p*N+i]) begin
                        acc  = acc | sd[i];
                        accv = accv | sv[i];
                    end
                m_rd[p] = accv ? acc : '0;
                m_rv[p] = accv;
            end
        if (cam_en_in) begin
            for (int i = 0; i < N; i++) m_cam[i] = sv[i] && (sd[i] == cam_entry_in);
            m_hit = (m_cam != '0);
        end
        for (int i = 0; i < N; i++) m_data[i] = nd[i];
        if (invalidate_en_in) m_valid = m_valid & ~invalidate_entry_decoded_in;
        m_valid = m_valid | wm;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk_in) begin
        if (chk_en) begin
            logic [N-1:0] ef;
            ef = '0;
            for (int i = N-1; i >= 0; i--) if (!m_valid[i]) ef = onehot(i);
            for (int p = 0; p < RP; p++) begin
                check($sformatf("rd_data%0d", p), 32'(read_entry_flatted_out[p*W +: W]), 32'(m_rd[p]));
                check($sformatf("rd_valid%0d", p), 32'(read_valid_out[p]), 32'(m_rv[p]));
            end
            check("cam_vec", 32'(cam_result_decoded_out), 32'(m_cam));
            check("cam_hit", 32'(cam_hit_out), 32'(m_hit));
            check("valid", 32'(entry_valid_flatted_out), 32'(m_valid));
            check("free", 32'(free_entry_decoded_out), 32'(ef));
            check("full", 32'(full_out), 32'(m_valid == '1));
            check("empty", 32'(empty_out), 32'(m_valid == '0));
        end
    end

    task automatic idle();
        read_en_in = '0;
        read_entry_addr_decoded_flatted_in = '0;
        write_en_in = '0;
        write_entry_addr_decoded_flatted_in = '0;
        write_entry_flatted_in = '0;
        invalidate_en_in = 1'b0;
        invalidate_entry_decoded_in = '0;
        cam_en_in = 1'b0;
        cam_entry_in = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        if (reset_in) model_edge();
        @(negedge clk_in);
        #1;
    endtask

    task automatic randomize_inputs();
        int r;
        for (int p = 0; p < WP; p++) begin
            write_en_in[p] = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            write_entry_addr_decoded_flatted_in[p*N +: N] =
                (r < 8) ? onehot(r % N) : (r == 8) ? N'(0) : N'($urandom);
            write_entry_flatted_in[p*W +: W] = W'($urandom_range(0, 7));
        end
        for (int p = 0; p < RP; p++) begin
            read_en_in[p] = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, N));
            read_entry_addr_decoded_flatted_in[p*N +: N] = (r == N) ? N'(0) : onehot(r);
        end
        invalidate_en_in = ($urandom_range(0, 3) == 0);
        invalidate_entry_decoded_in = N'($urandom);
        cam_en_in = 1'($urandom_range(0, 1));
        cam_entry_in = ($urandom_range(0, 1) == 1) ? m_data[$urandom_range(0, N-1)]
                                                   : W'($urandom_range(0, 7));
    endtask

    initial begin
        idle();
        reset_in = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_free", 32'(free_entry_decoded_out), 32'h1);
        check("rst_rd", 32'(read_entry_flatted_out), 32'h0);
        reset_in = 1'b1;

        // CAM of zero right after reset finds nothing
        cam_en_in = 1'b1; cam_entry_in = 8'h00;
        step(); idle();
        check("cam00_vec", 32'(cam_result_decoded_out), 32'h0);
        check("cam00_hit", 32'(cam_hit_out), 32'd0);

        // Same-cycle write and read of entry 0
        write_en_in[0] = 1'b1; write_entry_addr_decoded_flatted_in[0 +: N] = 4'b0001;
        write_entry_flatted_in[0 +: W] = 8'h77;
        read_en_in[0] = 1'b1; read_entry_addr_decoded_flatted_in[0 +: N] = 4'b0001;
        step(); idle();
`ifdef MULTI_PORT_CAM_REGFILE_BYPASS_EN
        check("fwd_data", 32'(read_entry_flatted_out[0 +: W]), 32'h77);
        check("fwd_valid", 32'(read_valid_out[0]), 32'd1);
`else
        check("fwd_data", 32'(read_entry_flatted_out[0 +: W]), 32'h00);
        check("fwd_valid", 32'(read_valid_out[0]), 32'd0);
`endif

        // Write A5 to entry 2, read it back on port 1
        write_en_in[0] = 1'b1; write_entry_addr_decoded_flatted_in[0 +: N] = 4'b0100;
        write_entry_flatted_in[0 +: W] = 8'hA5;
        step(); idle();
        read_en_in[1] = 1'b1; read_entry_addr_decoded_flatted_in[N +: N] = 4'b0100;
        step(); idle();
        check("a5_data", 32'(read_entry_flatted_out[W +: W]), 32'hA5);
        check("a5_valid", 32'(read_valid_out[1]), 32'd1);

        // Conflicting writes to entry 1: port 1 wins
        write_en_in = 2'b11;
        write_entry_addr_decoded_flatted_in = {4'b0010, 4'b0010};
        write_entry_flatted_in = {8'h22, 8'h11};
        step(); idle();
        read_en_in[0] = 1'b1; read_entry_addr_decoded_flatted_in[0 +: N] = 4'b0010;
        step(); idle();
        check("prio_data", 32'(read_entry_flatted_out[0 +: W]), 32'h22);

        // Fill the last entry, then invalidate entry 1 and search its old data
        write_en_in[0] = 1'b1; write_entry_addr_decoded_flatted_in[0 +: N] = 4'b1000;
        write_entry_flatted_in[0 +: W] = 8'h40;
        step(); idle();
        check("fill_full", 32'(full_out), 32'd1);
        check("fill_free", 32'(free_entry_decoded_out), 32'h0);
        invalidate_en_in = 1'b1; invalidate_entry_decoded_in = 4'b0010;
        step(); idle();
        check("inv_full", 32'(full_out), 32'd0);
        check("inv_free", 32'(free_entry_decoded_out), 32'h2);
        cam_en_in = 1'b1; cam_entry_in = 8'h22;
        step(); idle();
        check("inv_cam_hit", 32'(cam_hit_out), 32'd0);
        check("inv_cam_vec", 32'(cam_result_decoded_out), 32'h0);

        // Multi-hot write of 3C to entries 0 and 3, then CAM for it
        write_en_in[0] = 1'b1; write_entry_addr_decoded_flatted_in[0 +: N] = 4'b1001;
        write_entry_flatted_in[0 +: W] = 8'h3C;
        step(); idle();
        cam_en_in = 1'b1; cam_entry_in = 8'h3C;
        step(); idle();
        check("cam3c_vec", 32'(cam_result_decoded_out), 32'h9);
        check("cam3c_hit", 32'(cam_hit_out), 32'd1);

        // Disabled read and CAM ports hold their last results
        step();
        check("hold_rd", 32'(read_entry_flatted_out[0 +: W]), 32'h22);
        check("hold_cam", 32'(cam_result_decoded_out), 32'h9);

        // Write beats invalidate on the same entry
        write_en_in[0] = 1'b1; write_entry_addr_decoded_flatted_in[0 +: N] = 4'b0100;
        write_entry_flatted_in[0 +: W] = 8'h55;
        invalidate_en_in = 1'b1; invalidate_entry_decoded_in = 4'b1100;
        step(); idle();
        check("wr_vs_inv", 32'(entry_valid_flatted_out), 32'h5);

        // Randomized traffic checked every cycle by the compare process
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            step();
        end
        idle();

        // Asynchronous reset mid-cycle with a write pending
        write_en_in[1] = 1'b1; write_entry_addr_decoded_flatted_in[N +: N] = 4'b0001;
        write_entry_flatted_in[W +: W] = 8'h99;
        @(posedge clk_in);
        model_edge();
        #2;
        reset_in = 1'b0;
        model_reset();
        #1;
        check("arst_rd", 32'(read_entry_flatted_out), 32'h0);
        check("arst_rv", 32'(read_valid_out), 32'h0);
        check("arst_cam", 32'(cam_result_decoded_out), 32'h0);
        check("arst_hit", 32'(cam_hit_out), 32'd0);
        check("arst_valid", 32'(entry_valid_flatted_out), 32'h0);
        check("arst_empty", 32'(empty_out), 32'd1);
        check("arst_free", 32'(free_entry_decoded_out), 32'h1);
        step();
        check("arst_drop", 32'(entry_valid_flatted_out), 32'h0);
        reset_in = 1'b1;
        step();
        check("post_rst_wr", 32'(entry_valid_flatted_out), 32'h1);
        idle();
        read_en_in[0] = 1'b1; read_entry_addr_decoded_flatted_in[0 +: N] = 4'b0001;
        step(); idle();
        check("post_rst_rd", 32'(read_entry_flatted_out[0 +: W]), 32'h99);
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
